// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle control sequencer for the MIPS-subset datapath (lw/sw/j/jal/jr/beq/bne/addi/xori/add/sub/slt).
// Define MC_CTRL_PERF_EN to add the cycle_count / instr_count performance counters.
module mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        iord,
    output logic        mem_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        ext_zero,
    output logic [2:0]  alu_ctrl,
    output logic        instr_done,
    output logic        illegal
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
`endif
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_JR   = 6'h08;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_REXEC,
        S_RWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_HALT
    } state_t;

    typedef struct packed {
        logic       pc_we;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_we;
        logic       ir_we;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [2:0] alu_ctrl;
        logic       instr_done;
    } ctrl_t;

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl_q;
    logic   br_take_c;

    // Next-state function; opcode/funct come straight from the (stable) IR.
    function automatic state_t next_of(input state_t s, input logic [5:0] op, input logic [5:0] fn);
        state_t n;
        n = s;
        case (s)
            S_IDLE:   n = S_FETCH;
            S_FETCH:  n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:     n = S_MEMADR;
                    OP_R: begin
                        if (fn == FN_ADD || fn == FN_SUB || fn == FN_SLT) n = S_REXEC;
                        else if (fn == FN_JR)                              n = S_JR;
                        else                                               n = S_HALT;
                    end
                    OP_ADDI, OP_XORI: n = S_IEXEC;
                    OP_BEQ, OP_BNE:   n = S_BRANCH;
                    OP_J:             n = S_JUMP;
                    OP_JAL:           n = S_JAL;
                    default:          n = S_HALT;
                endcase
            end
            S_MEMADR: n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  n = S_MEMWB;
            S_REXEC:  n = S_RWB;
            S_IEXEC:  n = S_IWB;
            S_MEMWB, S_MEMWR, S_RWB, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR: n = S_FETCH;
            S_HALT:   n = S_HALT;
            default:  n = S_IDLE;
        endcase
        return n;
    endfunction

    // Control word for a state; evaluated for the upcoming state so outputs come from a register.
    function automatic ctrl_t outs_of(input state_t s, input logic [5:0] op, input logic [5:0] fn);
        ctrl_t o;
        o = '0;
        case (s)
            S_FETCH: begin
                o.ir_we     = 1'b1;
                o.alu_src_b = 2'b01;
                o.pc_we     = 1'b1;
            end
            S_DECODE: o.alu_src_b = 2'b11;
            S_MEMADR: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = 2'b10;
            end
            S_MEMRD:  o.iord = 1'b1;
            S_MEMWB: begin
                o.reg_we     = 1'b1;
                o.mem_to_reg = 2'b01;
                o.instr_done = 1'b1;
            end
            S_MEMWR: begin
                o.iord       = 1'b1;
                o.mem_we     = 1'b1;
                o.instr_done = 1'b1;
            end
            S_REXEC: begin
                o.alu_src_a = 1'b1;
                if (fn == FN_SUB)      o.alu_ctrl = ALU_SUB;
                else if (fn == FN_SLT) o.alu_ctrl = ALU_SLT;
                else                   o.alu_ctrl = ALU_ADD;
            end
            S_RWB: begin
                o.reg_we     = 1'b1;
                o.reg_dst    = 2'b01;
                o.instr_done = 1'b1;
            end
            S_IEXEC: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = 2'b10;
                if (op == OP_XORI) begin
                    o.alu_ctrl = ALU_XOR;
                    o.ext_zero = 1'b1;
                end
            end
            S_IWB: begin
                o.reg_we     = 1'b1;
                o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                o.alu_src_a  = 1'b1;
                o.alu_ctrl   = ALU_SUB;
                o.pc_src     = 2'b01;
                o.instr_done = 1'b1;
            end
            S_JUMP: begin
                o.pc_we      = 1'b1;
                o.pc_src     = 2'b10;
                o.instr_done = 1'b1;
            end
            S_JAL: begin
                o.pc_we      = 1'b1;
                o.pc_src     = 2'b10;
                o.reg_we     = 1'b1;
                o.reg_dst    = 2'b10;
                o.mem_to_reg = 2'b10;
                o.instr_done = 1'b1;
            end
            S_JR: begin
                o.pc_we      = 1'b1;
                o.pc_src     = 2'b11;
                o.instr_done = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    assign state_nxt = next_of(state, opcode, funct);

    // State, registered control word and sticky illegal flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            ctrl_q  <= '0;
            illegal <= 1'b0;
        end else begin
            state  <= state_nxt;
            ctrl_q <= outs_of(state_nxt, opcode, funct);
            if (state_nxt == S_HALT) illegal <= 1'b1;
        end
    end

    // Branch PC write is the only input-dependent output: it follows zero in the same cycle.
    assign br_take_c = (state == S_BRANCH) && ((opcode == OP_BNE) ? !zero : zero);

    assign pc_we      = !reset && (ctrl_q.pc_we || br_take_c);
    assign mem_we     = !reset && ctrl_q.mem_we;
    assign ir_we      = !reset && ctrl_q.ir_we;
    assign reg_we     = !reset && ctrl_q.reg_we;
    assign pc_src     = ctrl_q.pc_src;
    assign iord       = ctrl_q.iord;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign ext_zero   = ctrl_q.ext_zero;
    assign alu_ctrl   = ctrl_q.alu_ctrl;
    assign instr_done = ctrl_q.instr_done;

`ifdef MC_CTRL_PERF_EN
    // Active-cycle and retired-instruction counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (state != S_IDLE && state != S_HALT) cycle_count <= cycle_count + 32'd1;
            if (ctrl_q.instr_done)                  instr_count <= instr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl; each step compares the full control word against a hand-built constant.
module tb_mc_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        iord;
    logic        mem_we;
    logic        ir_we;
    logic        reg_we;
    logic [1:0]  reg_dst;
    logic [1:0]  mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        ext_zero;
    logic [2:0]  alu_ctrl;
    logic        instr_done;
    logic        illegal;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Field order: pc_we pc_src iord mem_we ir_we reg_we reg_dst mem_to_reg a b ext_zero alu done illegal
    logic [19:0] obs;
    assign obs = {pc_we, pc_src, iord, mem_we, ir_we, reg_we, reg_dst, mem_to_reg,
                  alu_src_a, alu_src_b, ext_zero, alu_ctrl, instr_done, illegal};

    localparam logic [19:0] E_ZERO     = 20'h0;
    localparam logic [19:0] E_FETCH    = {1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0};
    localparam logic [19:0] E_FETCH_RS = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0};
    localparam logic [19:0] E_DECODE   = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0};
    localparam logic [19:0] E_MEMADR   = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 3'b000, 1'b0, 1'b0};
    localparam logic [19:0] E_MEMRD    = {1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0};
    localparam logic [19:0] E_MEMWB    = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0};
    localparam logic [19:0] E_MEMWR    = {1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0};
    localparam logic [19:0] E_MEMWR_RS = {1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0};
    localparam logic [19:0] E_REX_SLT  = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 3'b011, 1'b0, 1'b0};
    localparam logic [19:0] E_REX_SUB  = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 3'b001, 1'b0, 1'b0};
    localparam logic [19:0] E_RWB      = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0};
    localparam logic [19:0] E_IEX_XORI = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 3'b010, 1'b0, 1'b0};
    localparam logic [19:0] E_IEX_ADDI = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 3'b000, 1'b0, 1'b0};
    localparam logic [19:0] E_IWB      = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0};
    localparam logic [19:0] E_BR_NT    = {1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 3'b001, 1'b1, 1'b0};
    localparam logic [19:0] E_BR_T     = {1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 3'b001, 1'b1, 1'b0};
    localparam logic [19:0] E_JUMP     = {1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0};
    localparam logic [19:0] E_JAL      = {1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0};
    localparam logic [19:0] E_JR       = {1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0};
    localparam logic [19:0] E_HALT     = 20'h00001;

    mc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .iord       (iord),
        .mem_we     (mem_we),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_zero   (ext_zero),
        .alu_ctrl   (alu_ctrl),
        .instr_done (instr_done),
        .illegal    (illegal)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_count(cycle_count),
        .instr_count(instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_total++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
        end
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 6'h23;
        funct  = 6'h00;
        zero   = 1'b0;
        cyc(); cyc();
        chk("reset_outputs", 32'(obs), 32'(E_ZERO));
        reset = 1'b0; #1;
        chk("idle_after_reset", 32'(obs), 32'(E_ZERO));

        // lw: 5 cycles, done only in the last
        cyc(); chk("lw_fetch",  32'(obs), 32'(E_FETCH));
        cyc(); chk("lw_decode", 32'(obs), 32'(E_DECODE));
        cyc(); chk("lw_memadr", 32'(obs), 32'(E_MEMADR));
        cyc(); chk("lw_memrd",  32'(obs), 32'(E_MEMRD));
        cyc(); chk("lw_memwb",  32'(obs), 32'(E_MEMWB));

        // slt then sub
        cyc(); chk("slt_fetch", 32'(obs), 32'(E_FETCH));
        opcode = 6'h00; funct = 6'h2A;
        cyc(); chk("slt_decode", 32'(obs), 32'(E_DECODE));
        cyc(); chk("slt_rexec",  32'(obs), 32'(E_REX_SLT));
        cyc(); chk("slt_rwb",    32'(obs), 32'(E_RWB));
        cyc(); chk("sub_fetch",  32'(obs), 32'(E_FETCH));
        funct = 6'h22;
        cyc(); chk("sub_decode", 32'(obs), 32'(E_DECODE));
        cyc(); chk("sub_rexec",  32'(obs), 32'(E_REX_SUB));
        cyc(); chk("sub_rwb",    32'(obs), 32'(E_RWB));

        // xori / addi
        cyc(); chk("xori_fetch", 32'(obs), 32'(E_FETCH));
        opcode = 6'h0E;
        cyc(); chk("xori_decode", 32'(obs), 32'(E_DECODE));
        cyc(); chk("xori_iexec",  32'(obs), 32'(E_IEX_XORI));
        cyc(); chk("xori_iwb",    32'(obs), 32'(E_IWB));
        cyc(); chk("addi_fetch",  32'(obs), 32'(E_FETCH));
        opcode = 6'h08;
        cyc(); chk("addi_decode", 32'(obs), 32'(E_DECODE));
        cyc(); chk("addi_iexec",  32'(obs), 32'(E_IEX_ADDI));
        cyc(); chk("addi_iwb",    32'(obs), 32'(E_IWB));

        // bne with zero=1 (not taken), then zero=0 (taken), then live zero toggle
        cyc(); chk("bne1_fetch", 32'(obs), 32'(E_FETCH));
        opcode = 6'h05; zero = 1'b1;
        cyc(); chk("bne1_decode", 32'(obs), 32'(E_DECODE));
        cyc(); chk("bne1_branch", 32'(obs), 32'(E_BR_NT));
        cyc(); chk("bne0_fetch",  32'(obs), 32'(E_FETCH));
        zero = 1'b0;
        cyc(); chk("bne0_decode", 32'(obs), 32'(E_DECODE));
        cyc(); chk("bne0_branch", 32'(obs), 32'(E_BR_T));
        zero = 1'b1; #1;
        chk("bne_zero_live", 32'(obs), 32'(E_BR_NT));

        // beq taken
        cyc(); chk("beq_fetch", 32'(obs), 32'(E_FETCH));
        opcode = 6'h04; zero = 1'b1;
        cyc(); chk("beq_decode", 32'(obs), 32'(E_DECODE));
        cyc(); chk("beq_branch", 32'(obs), 32'(E_BR_T));

        // jal, jr, j
        cyc(); chk("jal_fetch", 32'(obs), 32'(E_FETCH));
        opcode = 6'h03; zero = 1'b0;
        cyc(); chk("jal_decode", 32'(obs), 32'(E_DECODE));
        cyc(); chk("jal_exec",   32'(obs), 32'(E_JAL));
        cyc(); chk("jr_fetch",   32'(obs), 32'(E_FETCH));
        opcode = 6'h00; funct = 6'h08;
        cyc(); chk("jr_decode", 32'(obs), 32'(E_DECODE));
        cyc(); chk("jr_exec",   32'(obs), 32'(E_JR));
        cyc(); chk("j_fetch",   32'(obs), 32'(E_FETCH));
        opcode = 6'h02;
        cyc(); chk("j_decode", 32'(obs), 32'(E_DECODE));
        cyc(); chk("j_exec",   32'(obs), 32'(E_JUMP));

        // sw: 4 cycles
        cyc(); chk("sw_fetch", 32'(obs), 32'(E_FETCH));
        opcode = 6'h2B;
        cyc(); chk("sw_decode", 32'(obs), 32'(E_DECODE));
        cyc(); chk("sw_memadr", 32'(obs), 32'(E_MEMADR));
        cyc(); chk("sw_memwr",  32'(obs), 32'(E_MEMWR));

        // illegal opcode: HALT held regardless of inputs
        cyc(); chk("ill_fetch", 32'(obs), 32'(E_FETCH));
        opcode = 6'h3F;
        cyc(); chk("ill_decode", 32'(obs), 32'(E_DECODE));
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("halt_hold", 32'(obs), 32'(E_HALT));
            opcode = 6'(i * 5);
            zero   = ~zero;
        end
        reset = 1'b1; #1;
        chk("halt_reset_cycle", 32'(obs), 32'(E_HALT));
        cyc(); chk("halt_reset_idle", 32'(obs), 32'(E_ZERO));
        reset = 1'b0;
        cyc(); chk("resume_fetch", 32'(obs), 32'(E_FETCH));

        // reset during FETCH gates the enables immediately
        reset = 1'b1; #1;
        chk("fetch_reset_gate", 32'(obs), 32'(E_FETCH_RS));
        cyc(); chk("fetch_reset_idle", 32'(obs), 32'(E_ZERO));
        reset = 1'b0;
        cyc(); chk("perf_sw_fetch", 32'(obs), 32'(E_FETCH));

        // sw then j from a fresh reset
        opcode = 6'h2B;
        cyc(); chk("perf_sw_decode", 32'(obs), 32'(E_DECODE));
        cyc(); chk("perf_sw_memadr", 32'(obs), 32'(E_MEMADR));
        cyc(); chk("perf_sw_memwr",  32'(obs), 32'(E_MEMWR));
        cyc(); chk("perf_j_fetch",   32'(obs), 32'(E_FETCH));
        opcode = 6'h02;
        cyc(); chk("perf_j_decode", 32'(obs), 32'(E_DECODE));
        cyc(); chk("perf_j_exec",   32'(obs), 32'(E_JUMP));
        cyc(); chk("perf_next_fetch", 32'(obs), 32'(E_FETCH));
`ifdef MC_CTRL_PERF_EN
        chk("cycle_count_7", cycle_count, 32'd7);
        chk("instr_count_2", instr_count, 32'd2);
`endif

        // reset asserted in MEMWR suppresses the store that cycle
        opcode = 6'h2B;
        cyc(); chk("rst_sw_decode", 32'(obs), 32'(E_DECODE));
        cyc(); chk("rst_sw_memadr", 32'(obs), 32'(E_MEMADR));
        cyc(); chk("rst_sw_memwr",  32'(obs), 32'(E_MEMWR));
        reset = 1'b1; #1;
        chk("memwr_reset_gate", 32'(obs), 32'(E_MEMWR_RS));
        cyc(); chk("memwr_reset_idle", 32'(obs), 32'(E_ZERO));
`ifdef MC_CTRL_PERF_EN
        chk("cycle_count_clr", cycle_count, 32'd0);
        chk("instr_count_clr", instr_count, 32'd0);
`endif
        reset = 1'b0;
        cyc(); chk("final_fetch", 32'(obs), 32'(E_FETCH));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
